// File: rtl/ym2149_bus_master.sv
// ym2149_bus_master
// Converts single register read/write requests into YM2149 CPU-bus cycles.
// Sequence per access: address latch (BDIR/BC1 = 11), setup gap (00),
// write (10) or read (01) strobe, hold gap (00), then back to idle.
// All bus outputs are registered; the values for each phase are loaded on
// the edge that enters that phase.
module ym2149_bus_master #(
  parameter int ADDR_CYC = 9,
  parameter int GAP_CYC  = 2,
  parameter int DATA_CYC = 14
) (
  input  logic       I_clk,
  input  logic       I_reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] da_o,
  output logic       da_oe,
  input  logic [7:0] da_i
);

  localparam int MAX_AG  = (ADDR_CYC > GAP_CYC) ? ADDR_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_AG > DATA_CYC) ? MAX_AG : DATA_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  // Down-counter reload values: a phase of N cycles counts N-1 .. 0.
  localparam logic [CW-1:0] ADDR_LD = CW'(ADDR_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_q;
  logic [3:0]    addr_q;
  logic [7:0]    data_q;

  // Idle is the only state that can take a request.
  assign req_ready = (state == S_IDLE);

  // Phase sequencer with registered bus outputs and read capture.
  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of state/cnt; blocking = would leak updates mid-block.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      addr_q   <= 4'h0;
      data_q   <= 8'h00;
      busy     <= 1'b0;
      bdir     <= 1'b0;
      bc1      <= 1'b0;
      da_o     <= 8'h00;
      da_oe    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      // rd_valid is a strobe; only the ACCESS exit of a read raises it.
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q   <= req_wr;
            addr_q <= req_addr;
            data_q <= req_data;
            state  <= S_ADDR;
            cnt    <= ADDR_LD;
            busy   <= 1'b1;
            bdir   <= 1'b1;
            bc1    <= 1'b1;
            da_o   <= {4'h0, req_addr};
            da_oe  <= 1'b1;
          end
        end
        S_ADDR: begin
          if (cnt == '0) begin
            state <= S_SETUP;
            cnt   <= GAP_LD;
            bdir  <= 1'b0;
            bc1   <= 1'b0;
            // Writes present data early for setup; reads release the bus.
            da_o  <= wr_q ? data_q : 8'h00;
            da_oe <= wr_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_ACCESS;
            cnt   <= DATA_LD;
            bdir  <= wr_q;
            bc1   <= ~wr_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state <= S_HOLD;
            cnt   <= GAP_LD;
            bdir  <= 1'b0;
            bc1   <= 1'b0;
            if (!wr_q) begin
              // Sample at the end of the full read strobe.
              rd_data  <= da_i;
              rd_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            da_o  <= 8'h00;
            da_oe <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          bdir  <= 1'b0;
          bc1   <= 1'b0;
          da_o  <= 8'h00;
          da_oe <= 1'b0;
        end
      endcase
    end
  end

  // Parameters below 1 would make a phase wrap the counter.
  initial begin : param_guard
  end

endmodule

// File: tb/tb_ym2149_bus_master.sv
// Directed bench for ym2149_bus_master: default-timing instance plus a
// minimum-timing instance, with a continuous bus-legality monitor.
module tb_ym2149_bus_master;

  logic       clk;
  logic       rst_n;

  // Default-parameter instance
  logic       req_valid, req_ready, req_wr;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       rd_valid, busy, bdir, bc1, da_oe;
  logic [7:0] rd_data, da_o, da_i;

  // Minimum-timing instance
  logic       s_valid, s_ready, s_wr;
  logic [3:0] s_addr;
  logic [7:0] s_data;
  logic       s_rd_valid, s_busy, s_bdir, s_bc1, s_da_oe;
  logic [7:0] s_rd_data, s_da_o, s_da_i;

  int errors = 0;
  int checks = 0;
  int bus_viol = 0;

  ym2149_bus_master dut (
    .I_clk(clk), .I_reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .bdir(bdir), .bc1(bc1), .da_o(da_o), .da_oe(da_oe), .da_i(da_i)
  );

  ym2149_bus_master #(.ADDR_CYC(1), .GAP_CYC(1), .DATA_CYC(1)) dut_min (
    .I_clk(clk), .I_reset_n(rst_n),
    .req_valid(s_valid), .req_ready(s_ready), .req_wr(s_wr),
    .req_addr(s_addr), .req_data(s_data),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .busy(s_busy),
    .bdir(s_bdir), .bc1(s_bc1), .da_o(s_da_o), .da_oe(s_da_oe), .da_i(s_da_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus legality monitor for both instances, sampled mid-cycle.
  logic [1:0] prev_code = 2'b00;
  logic [1:0] s_prev_code = 2'b00;
  always @(negedge clk) begin
    if (da_oe && !bdir && bc1) begin
      $display("FAIL bus_oe_during_read(main): da_oe=%b bdir=%b bc1=%b", da_oe, bdir, bc1);
      bus_viol = bus_viol + 1;
    end
    if (prev_code != 2'b00 && {bdir, bc1} != 2'b00 && prev_code != {bdir, bc1}) begin
      $display("FAIL bus_code_jump(main): %b -> %b", prev_code, {bdir, bc1});
      bus_viol = bus_viol + 1;
    end
    if (s_da_oe && !s_bdir && s_bc1) begin
      $display("FAIL bus_oe_during_read(min): da_oe=%b", s_da_oe);
      bus_viol = bus_viol + 1;
    end
    if (s_prev_code != 2'b00 && {s_bdir, s_bc1} != 2'b00 && s_prev_code != {s_bdir, s_bc1}) begin
      $display("FAIL bus_code_jump(min): %b -> %b", s_prev_code, {s_bdir, s_bc1});
      bus_viol = bus_viol + 1;
    end
    prev_code   = {bdir, bc1};
    s_prev_code = {s_bdir, s_bc1};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one default-timing transaction from its first ADDR cycle to the
  // following IDLE cycle, checking every cycle against the expected phase.
  // For reads, da_i carries rd_exp only during the ACCESS window.
  task automatic run_txn_and_verify(input string tag, input logic wr,
                                    input logic [3:0] addr, input logic [7:0] data,
                                    input logic [7:0] rd_exp);
    logic [13:0] obs, exp;
    logic [1:0]  code;
    logic        oe;
    logic [7:0]  dexp;
    for (int i = 0; i < 27; i++) begin
      if (i == 11) da_i = rd_exp;
      if (i == 25) da_i = 8'hAA;
      if (i < 9)       code = 2'b11;
      else if (i < 11) code = 2'b00;
      else if (i < 25) code = wr ? 2'b10 : 2'b01;
      else             code = 2'b00;
      oe   = (i < 9) ? 1'b1 : wr;
      dexp = (i < 9) ? {4'h0, addr} : (wr ? data : 8'h00);
      // {ready, busy, bdir, bc1, da_oe, da_o, rd_valid}
      exp = {1'b0, 1'b1, code, oe, dexp, (!wr && i == 25)};
      obs = {req_ready, busy, bdir, bc1, da_oe, da_o, rd_valid};
      checks++;
      if (obs !== exp) begin
        $display("FAIL %s cycle %0d: got rdy/busy/bdir/bc1/oe/da/rdv=%b expected %b", tag, i, obs, exp);
        errors++;
      end
      if (!wr && i == 25) begin
        checks++;
        if (rd_data !== rd_exp) begin
          $display("FAIL %s rd_data: got %h expected %h", tag, rd_data, rd_exp);
          errors++;
        end
      end
      tick();
    end
    // 28th cycle after the accept cycle: back in IDLE.
    exp = {1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    obs = {req_ready, busy, bdir, bc1, da_oe, da_o, rd_valid};
    checks++;
    if (obs !== exp) begin
      $display("FAIL %s idle_return: got %b expected %b", tag, obs, exp);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 4'h0; req_data = 8'h00;
    s_valid = 1'b0; s_wr = 1'b0; s_addr = 4'h0; s_data = 8'h00;
    da_i = 8'hAA; s_da_i = 8'h00;
    #23;
    checks++;
    if ({req_ready, busy, bdir, bc1, da_oe, da_o, rd_valid, rd_data} !== {1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00}) begin
      $display("FAIL reset_values: got %b", {req_ready, busy, bdir, bc1, da_oe, da_o, rd_valid, rd_data});
      errors++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({req_ready, busy, bdir, bc1, da_oe} !== 5'b10000) begin
      $display("FAIL after_release: got %b expected 10000", {req_ready, busy, bdir, bc1, da_oe});
      errors++;
    end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'h7; req_data = 8'h38;
    tick();
    req_valid = 1'b0;
    run_txn_and_verify("write_r7", 1'b1, 4'h7, 8'h38, 8'hAA);
    tick();
  endtask

  task automatic test_read();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'h8; req_data = 8'hC3;
    tick();
    req_valid = 1'b0;
    run_txn_and_verify("read_r8", 1'b0, 4'h8, 8'hC3, 8'h0F);
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h0F) begin
      $display("FAIL read_r8 after: got rd_valid=%b rd_data=%h expected 0/0f", rd_valid, rd_data);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'h0; req_data = 8'h55;
    tick();
    // Next request waits on the bus while the first runs.
    req_addr = 4'h1; req_data = 8'h01;
    run_txn_and_verify("b2b_r0", 1'b1, 4'h0, 8'h55, 8'hAA);
    tick();
    req_addr = 4'h7; req_data = 8'h3E;
    run_txn_and_verify("b2b_r1", 1'b1, 4'h1, 8'h01, 8'hAA);
    tick();
    req_valid = 1'b0;
    run_txn_and_verify("b2b_r7", 1'b1, 4'h7, 8'h3E, 8'hAA);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({req_ready, busy, bdir, bc1} !== 4'b1000) begin
        $display("FAIL b2b_no_dup cycle %0d: got %b expected 1000", i, {req_ready, busy, bdir, bc1});
        errors++;
      end
    end
  endtask

  task automatic test_min_params();
    logic [1:0] exp_code [5];
    logic       exp_rdy  [5];
    logic       exp_oe   [5];
    logic [7:0] exp_da   [5];
    exp_code[0] = 2'b11; exp_rdy[0] = 1'b0; exp_oe[0] = 1'b1; exp_da[0] = 8'h03;
    exp_code[1] = 2'b00; exp_rdy[1] = 1'b0; exp_oe[1] = 1'b1; exp_da[1] = 8'hA5;
    exp_code[2] = 2'b10; exp_rdy[2] = 1'b0; exp_oe[2] = 1'b1; exp_da[2] = 8'hA5;
    exp_code[3] = 2'b00; exp_rdy[3] = 1'b0; exp_oe[3] = 1'b1; exp_da[3] = 8'hA5;
    exp_code[4] = 2'b00; exp_rdy[4] = 1'b1; exp_oe[4] = 1'b0; exp_da[4] = 8'h00;
    s_valid = 1'b1; s_wr = 1'b1; s_addr = 4'h3; s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({s_ready, s_bdir, s_bc1, s_da_oe, s_da_o} !== {exp_rdy[i], exp_code[i], exp_oe[i], exp_da[i]}) begin
        $display("FAIL min_params cycle %0d: got %b expected %b", i,
                 {s_ready, s_bdir, s_bc1, s_da_oe, s_da_o}, {exp_rdy[i], exp_code[i], exp_oe[i], exp_da[i]});
        errors++;
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_reset_mid_read();
    int strobes;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'h8; req_data = 8'h00;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 11) da_i = 8'h0F;
      tick();
    end
    // Now in the 5th ACCESS cycle; confirm, then reset between edges.
    checks++;
    if ({bdir, bc1, da_oe} !== 3'b010) begin
      $display("FAIL mid_read_pre: got bdir/bc1/oe=%b expected 010", {bdir, bc1, da_oe});
      errors++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bdir, bc1, da_oe, busy, rd_valid, req_ready} !== 6'b000001) begin
      $display("FAIL mid_read_async: got bdir/bc1/oe/busy/rdv/rdy=%b expected 000001",
               {bdir, bc1, da_oe, busy, rd_valid, req_ready});
      errors++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    da_i = 8'hAA;
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rd_valid) strobes++;
    end
    checks++;
    if (strobes !== 0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL mid_read_release: got strobes=%0d ready=%b busy=%b expected 0/1/0", strobes, req_ready, busy);
      errors++;
    end
  endtask

  task automatic test_bus_monitor();
    tick();
    checks++;
    if (bus_viol !== 0) begin
      $display("FAIL bus_monitor: got %0d violations expected 0", bus_viol);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_min_params();
    test_reset_mid_read();
    test_bus_monitor();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
